// File: rtl/status_telemetry_tx.sv
// Status telemetry framer: sends a 4-byte frame (header, status, seq, chk) over a
// valid/ready byte link. A frame is sent on a status change, after reset, or on heartbeat expiry.
module status_telemetry_tx #(
    parameter int          HEARTBEAT_CYCLES = 1000,
    parameter logic [7:0]  HEADER           = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] fsm_state,
    input  logic [1:0] comm_channel,
    input  logic       system_fault,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_last,
    output logic       busy
);

    localparam int HBW = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HBW-1:0] HB_MAX = HBW'(HEARTBEAT_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [7:0]     seq_q, seq_d;
    logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
    logic [7:0]     snap_q, snap_d;
    logic           boot_q, boot_d;

    logic [7:0] live_status;
    logic       frame_start;
    logic [7:0] cur_byte;

    assign live_status = {system_fault, 2'b00, comm_channel, fsm_state};

    // Triggers are only evaluated in IDLE, which enforces an idle cycle between frames.
    assign frame_start = (state_q == S_IDLE) &&
                         ((live_status != snap_q) || boot_q || (hb_cnt_q == HB_MAX));

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = snap_q;
            2'd2:    cur_byte = seq_q;
            default: cur_byte = HEADER ^ snap_q ^ seq_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        snap_d   = snap_q;
        boot_d   = boot_q;
        hb_cnt_d = hb_cnt_q;

        if (frame_start) begin
            snap_d  = live_status;
            boot_d  = 1'b0;
            state_d = S_SEND;
            idx_d   = 2'd0;
        end else if ((state_q == S_SEND) && tx_ready) begin
            if (idx_q == 2'd3) begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                seq_d   = seq_q + 8'd1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        // Heartbeat keeps running through SEND so a long stall still yields a prompt next frame.
        if (frame_start) begin
            hb_cnt_d = '0;
        end else if (hb_cnt_q != HB_MAX) begin
            hb_cnt_d = hb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            seq_q    <= 8'h00;
            hb_cnt_q <= '0;
            snap_q   <= 8'h00;
            boot_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            hb_cnt_q <= hb_cnt_d;
            snap_q   <= snap_d;
            boot_q   <= boot_d;
        end
    end

    assign tx_valid = (state_q == S_SEND);
    assign busy     = (state_q == S_SEND);
    assign tx_last  = (state_q == S_SEND) && (idx_q == 2'd3);
    assign tx_data  = (state_q == S_SEND) ? cur_byte : 8'h00;

endmodule
